// File: rtl/regfile_serial_loader_if.sv
// Command-side bundle between the serial loader and its driver: the serial link and
// control strobes in, the register file io_in image out.
interface regfile_serial_loader_if;
  logic       sdata;
  logic       sframe;
  logic       scan_en;
  logic       parity_en;
  logic       raddr_clr;
  logic [7:0] io_out;

  modport master (output sdata, sframe, scan_en, parity_en, raddr_clr, input io_out);
  modport slave  (input sdata, sframe, scan_en, parity_en, raddr_clr, output io_out);
endinterface

// File: rtl/regfile_serial_loader.sv
// Deserializes 6-bit parity-checked write frames into a one-cycle we pulse for the
// latch register file, and optionally scans the read address through all entries.
module regfile_serial_loader #(
  parameter int SCAN_DIV = 1
) (
  input logic                     clk,
  input logic                     reset,
  regfile_serial_loader_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

  logic [1:0] state;
  logic [2:0] cnt;
  logic [5:0] sr;
  logic       sframe_q;
  logic [2:0] wdata;
  logic [1:0] waddr;
  logic       we;
  logic [1:0] raddr;
  logic [7:0] div;
  logic       frame_ok;

  assign frame_ok   = (cnt == 3'd6) && (!bus.parity_en || (^sr == 1'b0));
  assign bus.io_out = {raddr[1], raddr[0], we, waddr, wdata};

  // Write path: WRITE and HOLD keep wdata/waddr stable around and after the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      sr       <= 6'd0;
      sframe_q <= 1'b1;
      wdata    <= 3'd0;
      waddr    <= 2'd0;
      we       <= 1'b0;
    end else begin
      sframe_q <= bus.sframe;
      we       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sframe && !sframe_q) begin
            sr    <= {5'd0, bus.sdata};
            cnt   <= 3'd1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.sframe) begin
            sr  <= {sr[4:0], bus.sdata};
            cnt <= (cnt == 3'd7) ? 3'd7 : cnt + 3'd1;
          end else if (frame_ok) begin
            wdata <= sr[5:3];
            waddr <= sr[2:1];
            we    <= 1'b1;
            state <= WRITE;
          end else begin
            state <= IDLE;
          end
        end
        WRITE:   state <= HOLD;
        default: state <= IDLE;
      endcase
    end
  end

  // Read-address scanner, independent of the write FSM.
  always_ff @(posedge clk) begin
    if (reset || bus.raddr_clr) begin
      raddr <= 2'd0;
      div   <= 8'd0;
    end else if (bus.scan_en) begin
      if (div == DIV_LAST) begin
        div   <= 8'd0;
        raddr <= raddr + 2'd1;
      end else begin
        div <= div + 8'd1;
      end
    end
  end

endmodule
